// File: rtl/esc_pkg.sv
// Shared types for the escalation sender/receiver pair.
// The tx/rx pairs are 2-bit packed structs with the positive rail in the MSB,
// so a struct value and the raw 2-bit port slice are interchangeable.
package esc_pkg;

   typedef struct packed {
      logic esc_p;
      logic esc_n;
   } esc_tx_t;

   typedef struct packed {
      logic resp_p;
      logic resp_n;
   } esc_rx_t;

   // Idle levels of the differential pairs: positive rail low, negative rail high.
   localparam esc_tx_t ESC_TX_DEFAULT = 2'b01;
   localparam esc_rx_t ESC_RX_DEFAULT = 2'b01;

   typedef enum logic [2:0] {
      Idle,
      PingWait,
      PingChk,
      EscWait,
      EscChk
   } esc_sender_state_e;

endpackage : esc_pkg

// File: rtl/esc_sender.sv
// Escalation sender for one severity lane.
// Turns the escalation-enable and ping-request levels into the differential
// esc_tx pair, checks the receiver's differential response and reports ping
// success and integrity failures. All outputs come straight from flops.
//
// Build option: define ESC_SENDER_INTEG_STICKY_EN to make integ_fail_o hold
// at 1 from the first detected failure until reset; otherwise it pulses for
// one cycle per detected failure.
//
// PingChecks must be even and within 2..8: the expected response alternates
// 1,0,1,0,... and is derived from the LSB of the check counter.
module esc_sender
   import esc_pkg::*;
#(
   parameter int PingChecks = 4
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       ping_en_i,
   input  logic       esc_en_i,
   output logic [1:0] esc_tx_o,
   input  logic [1:0] esc_rx_i,
   output logic       ping_ok_o,
   output logic       integ_fail_o
);

   localparam int CntW = $clog2(PingChecks);

   esc_sender_state_e state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   esc_tx_t           tx_q, tx_d;
   logic              esc_p_d;
   logic              ping_ok_q, ping_ok_d;
   logic              integ_fail_q, fail_d;

   esc_rx_t           rx;
   logic              diff_fail;
   logic              pat_ok;
   logic              last_chk;

   assign rx        = esc_rx_t'(esc_rx_i);
   // Both rails equal means the pair itself is broken, whatever the state.
   assign diff_fail = (rx.resp_p == rx.resp_n);
   // Expected response alternates 1,0,1,0 starting at counter value 0.
   assign pat_ok    = (rx.resp_p == ~cnt_q[0]);
   assign last_chk  = (cnt_q == CntW'(PingChecks - 1));
   assign tx_d      = '{esc_p: esc_p_d, esc_n: ~esc_p_d};

   // Next-state, counter and next-output decode; escalation always wins over ping.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it
      // unassigned, which would otherwise infer a latch.
      state_d  = state_q;
      cnt_d    = cnt_q;
      esc_p_d  = 1'b0;
      ping_ok_d = 1'b0;
      fail_d   = diff_fail;

      unique case (state_q)
         Idle: begin
            if (esc_en_i) begin
               esc_p_d = 1'b1;
               state_d = EscWait;
            end else if (ping_en_i) begin
               esc_p_d = 1'b1;
               state_d = PingWait;
            end
         end

         // Receiver is still reacting to the ping pulse; nothing to check yet.
         PingWait: begin
            if (esc_en_i) begin
               esc_p_d = 1'b1;
               state_d = EscWait;
            end else begin
               cnt_d   = '0;
               state_d = PingChk;
            end
         end

         PingChk: begin
            if (esc_en_i) begin
               // Abort the ping silently and start escalating.
               esc_p_d = 1'b1;
               state_d = EscWait;
            end else if (diff_fail) begin
               state_d = Idle;
            end else if (!pat_ok) begin
               fail_d  = 1'b1;
               state_d = Idle;
            end else if (last_chk) begin
               ping_ok_d = 1'b1;
               state_d   = Idle;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end

         // First escalation cycle: the receiver has not answered yet.
         EscWait: begin
            if (esc_en_i) begin
               esc_p_d = 1'b1;
               cnt_d   = '0;
               state_d = EscChk;
            end else begin
               state_d = Idle;
            end
         end

         // Counter wraps freely here; only its LSB (the expected toggle) matters.
         EscChk: begin
            if (esc_en_i) begin
               esc_p_d = 1'b1;
               cnt_d   = cnt_q + CntW'(1);
               if (!pat_ok) begin
                  fail_d = 1'b1;
               end
            end else begin
               state_d = Idle;
            end
         end

         default: begin
            state_d = Idle;
         end
      endcase
   end

   // State, counter and registered outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= Idle;
         cnt_q        <= '0;
         tx_q         <= ESC_TX_DEFAULT;
         ping_ok_q    <= 1'b0;
         integ_fail_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge
         // values regardless of statement order.
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         tx_q      <= tx_d;
         ping_ok_q <= ping_ok_d;
`ifdef ESC_SENDER_INTEG_STICKY_EN
         integ_fail_q <= integ_fail_q | fail_d;
`else
         integ_fail_q <= fail_d;
`endif
      end
   end

   assign esc_tx_o     = tx_q;
   assign ping_ok_o    = ping_ok_q;
   assign integ_fail_o = integ_fail_q;

endmodule : esc_sender

// File: tb/tb_esc_sender.sv
// Self-checking bench for esc_sender.
// Each scenario is a short timeline: per-cycle stimulus plus per-cycle
// expected outputs, written from the timing rules (ping at cycle s gives a
// pulse at s+1, checks at s+2.., result one cycle after the deciding check).
// Honours ESC_SENDER_INTEG_STICKY_EN the same way the design does.
module tb_esc_sender;
   import esc_pkg::*;

   localparam int PingChecks = 4;
   localparam int N          = 32;
   localparam int ScnLen     = 24;

   logic       clk = 1'b0;
   logic       rst_ni = 1'b0;
   logic       ping_en_i = 1'b0;
   logic       esc_en_i = 1'b0;
   logic [1:0] esc_rx_i = ESC_RX_DEFAULT;
   logic [1:0] esc_tx_o;
   logic       ping_ok_o;
   logic       integ_fail_o;

   int n_checks = 0;
   int n_fail   = 0;
   bit sticky_acc = 1'b0;

   // Scenario timeline
   bit         st_ping [N];
   bit         st_esc  [N];
   logic [1:0] st_rx   [N];
   bit         ex_p    [N];
   bit         ex_ok   [N];
   bit         fev     [N];

   esc_sender #(.PingChecks(PingChecks)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_ni),
      .ping_en_i   (ping_en_i),
      .esc_en_i    (esc_en_i),
      .esc_tx_o    (esc_tx_o),
      .esc_rx_i    (esc_rx_i),
      .ping_ok_o   (ping_ok_o),
      .integ_fail_o(integ_fail_o)
   );

   always #5 clk = ~clk;

   initial begin
      #500us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Receiver reply for the j-th checked cycle: 1,0,1,0,...
   function automatic logic [1:0] pat(input int j);
      return (j % 2 == 0) ? 2'b10 : 2'b01;
   endfunction

   function automatic logic [1:0] glitch();
      return ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
   endfunction

   task automatic clear_scn();
      for (int i = 0; i < N; i++) begin
         st_ping[i] = 1'b0;
         st_esc[i]  = 1'b0;
         st_rx[i]   = ESC_RX_DEFAULT;
         ex_p[i]    = 1'b0;
         ex_ok[i]   = 1'b0;
         fev[i]     = 1'b0;
      end
   endtask

   // Ping requested in cycle s. err_kind: 0 good, 1 wrong value at check e,
   // 2 broken pair at check e. hold keeps ping_en up through the ok cycle,
   // which must launch a second (good) ping from that Idle cycle.
   task automatic add_ping(input int s, input int err_kind, input int e, input bit hold);
      int last;
      st_ping[s] = 1'b1;
      ex_p[s+1]  = 1'b1;
      last = (err_kind == 0) ? PingChecks - 1 : e;
      for (int j = 0; j <= last; j++) st_rx[s+2+j] = pat(j);
      if (err_kind == 1) begin
         st_rx[s+2+e] = pat(e + 1);
         fev[s+3+e]   = 1'b1;
      end else if (err_kind == 2) begin
         st_rx[s+2+e] = glitch();
      end else begin
         ex_ok[s+2+PingChecks] = 1'b1;
         if (hold) begin
            for (int c = s; c <= s + 2 + PingChecks; c++) st_ping[c] = 1'b1;
            add_ping(s + 2 + PingChecks, 0, 0, 1'b0);
         end
      end
   endtask

   // Escalation enable high in cycles s..s+d-1. mode: 0 clean, 1 resp_p stuck
   // at 1, 2 one broken-pair cycle. Cycle s+d carries an unchecked reply.
   task automatic add_esc(input int s, input int d, input int mode);
      for (int c = s; c < s + d; c++) st_esc[c] = 1'b1;
      for (int c = s + 1; c <= s + d; c++) ex_p[c] = 1'b1;
      for (int j = 0; s + 2 + j <= s + d - 1; j++) begin
         if (mode == 1) begin
            st_rx[s+2+j] = 2'b10;
            if (j % 2 == 1) fev[s+3+j] = 1'b1;
         end else begin
            st_rx[s+2+j] = pat(j);
         end
      end
      if (mode == 2 && d >= 3) st_rx[s+2+$urandom_range(0, d - 3)] = glitch();
      st_rx[s+d] = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
   endtask

   // Drive the timeline and compare every cycle; a broken pair in any cycle
   // is a failure reported in the next cycle.
   task automatic run_scn(input int len);
      bit exf;
      for (int c = 0; c + 1 < len; c++)
         if (st_rx[c][1] == st_rx[c][0]) fev[c+1] = 1'b1;
      for (int c = 0; c < len; c++) begin
         @(posedge clk);
         #1;
         ping_en_i = st_ping[c];
         esc_en_i  = st_esc[c];
         esc_rx_i  = st_rx[c];
         @(negedge clk);
`ifdef ESC_SENDER_INTEG_STICKY_EN
         sticky_acc = sticky_acc | fev[c];
         exf = sticky_acc;
`else
         exf = fev[c];
`endif
         check("esc_tx", 32'(esc_tx_o), ex_p[c] ? 32'h2 : 32'h1);
         check("ping_ok", 32'(ping_ok_o), 32'(ex_ok[c]));
         check("integ_fail", 32'(integ_fail_o), 32'(exf));
      end
   endtask

   initial begin
      int kind;
      int e;
      int a;

      // Reset state
      #12;
      check("rst_esc_tx", 32'(esc_tx_o), 32'h1);
      check("rst_ping_ok", 32'(ping_ok_o), 32'h0);
      check("rst_integ_fail", 32'(integ_fail_o), 32'h0);
      @(negedge clk);
      rst_ni = 1'b1;

      // Directed: good ping, 1,1 reply, held ping, clean and stuck escalation,
      // abort in PingChk, idle pair glitch.
      clear_scn(); add_ping(0, 0, 0, 1'b0); run_scn(ScnLen);
      clear_scn(); add_ping(0, 1, 1, 1'b0); run_scn(ScnLen);
      clear_scn(); add_ping(0, 0, 0, 1'b1); run_scn(ScnLen);
      clear_scn(); add_esc(0, 10, 0); run_scn(ScnLen);
      clear_scn(); add_esc(0, 10, 1); run_scn(ScnLen);
      clear_scn(); add_ping(0, 0, 0, 1'b0);
      for (int c = 0; c < N; c++) begin st_rx[c] = ESC_RX_DEFAULT; ex_ok[c] = 1'b0; end
      st_rx[2] = pat(0); add_esc(3, 6, 0); run_scn(ScnLen);
      clear_scn(); st_rx[2] = 2'b11; run_scn(ScnLen);

      // Randomized scenarios
      for (int n = 0; n < 45; n++) begin
         clear_scn();
         kind = $urandom_range(0, 3);
         case (kind)
            0: begin
               e = $urandom_range(0, PingChecks - 1);
               a = $urandom_range(0, 2);
               add_ping(0, a, e, (a == 0) && ($urandom_range(0, 1) != 0));
            end
            1: add_esc(0, $urandom_range(1, 12), $urandom_range(0, 2));
            2: begin
               add_ping(0, 0, 0, 1'b0);
               a = $urandom_range(1, 1 + PingChecks);
               for (int c = 0; c < N; c++) begin st_rx[c] = ESC_RX_DEFAULT; ex_ok[c] = 1'b0; end
               for (int c = 2; c < a; c++) st_rx[c] = pat(c - 2);
               add_esc(a, $urandom_range(1, 12), $urandom_range(0, 2));
            end
            default: st_rx[$urandom_range(1, 4)] = glitch();
         endcase
         run_scn(ScnLen);
      end

      // Reset in the middle of an escalation
      @(posedge clk); #1; esc_en_i = 1'b1; esc_rx_i = 2'b01;
      @(posedge clk); #1; esc_rx_i = 2'b01;
      @(posedge clk); #1; esc_rx_i = 2'b10;
      @(negedge clk);
      check("mid_esc_tx", 32'(esc_tx_o), 32'h2);
      #2 rst_ni = 1'b0;
      #1;
      check("mid_rst_esc_tx", 32'(esc_tx_o), 32'h1);
      check("mid_rst_ping_ok", 32'(ping_ok_o), 32'h0);
      check("mid_rst_integ_fail", 32'(integ_fail_o), 32'h0);
      esc_en_i = 1'b0;
      esc_rx_i = ESC_RX_DEFAULT;
      @(negedge clk);
      rst_ni = 1'b1;
      sticky_acc = 1'b0;
      clear_scn(); run_scn(6);
      clear_scn(); add_ping(0, 0, 0, 1'b0); run_scn(ScnLen);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_esc_sender
